vmul_seq: RTL and testbench
===========================

Name: vmul_seq

Overview:
- Issue sequencer on the initiator side of the vector multiplier's request interface (vec0/vec1/valid/sew/opSel/widen/addr).
- Accepts one vector-multiply command at a time and walks the source registers one 64-bit chunk per granted cycle.
- Reads both operands from a shared register-file read port and issues each chunk to the multiplier.
- Counts returning results and pulses done once the last result has come back from the fixed-latency pipeline.

Parameters:
- REQ_DATA_WIDTH, 64, width of one operand/result chunk.
- REQ_ADDR_WIDTH, 32, register-file chunk address width.
- SEW_WIDTH, 2, element-width code width.
- OPSEL_WIDTH, 2, multiplier op-select width.
- CNT_WIDTH, 8, width of chunk count and outstanding counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_vs1  in  REQ_ADDR_WIDTH  base chunk address, operand 0
- cmd_vs2  in  REQ_ADDR_WIDTH  base chunk address, operand 1
- cmd_vd  in  REQ_ADDR_WIDTH  base chunk address, destination
- cmd_len  in  CNT_WIDTH  number of source chunks
- cmd_sew  in  SEW_WIDTH  element width code
- cmd_opsel  in  OPSEL_WIDTH  multiplier op select
- cmd_widen  in  1  widening op
- rd_req  out  1  register-file read request
- rd_gnt  in  1  read grant, same cycle as rd_req
- rd_addr0  out  REQ_ADDR_WIDTH  operand-0 read address
- rd_addr1  out  REQ_ADDR_WIDTH  operand-1 read address
- rd_data0  in  REQ_DATA_WIDTH  operand-0 data, one cycle after grant
- rd_data1  in  REQ_DATA_WIDTH  operand-1 data, one cycle after grant
- mul_vec0  out  REQ_DATA_WIDTH  multiplier operand 0
- mul_vec1  out  REQ_DATA_WIDTH  multiplier operand 1
- mul_valid  out  1  multiplier request valid
- mul_sew  out  SEW_WIDTH  multiplier element width
- mul_opsel  out  OPSEL_WIDTH  multiplier op select
- mul_widen  out  1  multiplier widen flag
- mul_addr  out  REQ_ADDR_WIDTH  destination address tag sent with the request
- mul_out_valid  in  1  result-valid strobe returned by the multiplier
- busy  out  1  command in progress
- cmd_done  out  1  one-cycle pulse: all results of the command returned

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; idx=0; outstanding=0.
  - mul_valid, mul_addr, mul_sew, mul_opsel, mul_widen, cmd_done, busy = 0.
  - rd_req=0; cmd_ready=1 once out of reset.
- Command fields are latched on cmd_valid & cmd_ready. stride = cmd_widen ? 2 : 1.
- State IDLE:
  - cmd_ready=1, rd_req=0.
  - On accept with cmd_len!=0: go to ISSUE, busy=1.
  - On accept with cmd_len==0: stay IDLE, cmd_done=1 for one cycle on the next cycle, no reads issued.
- State ISSUE:
  - cmd_ready=0, rd_req=1.
  - rd_addr0 = vs1+idx and rd_addr1 = vs2+idx, driven from registers.
  - On rd_gnt: idx increments, outstanding increments.
  - If idx==len-1 at the grant, go to DRAIN.
  - When rd_gnt=0, nothing advances and rd_req/addresses hold.
- Issue timing:
  - A grant in cycle t gives mul_valid=1 in cycle t+1, registered.
  - In t+1, mul_addr = vd + idx_t*stride; mul_sew/mul_opsel/mul_widen come from the latched command.
  - mul_vec0/mul_vec1 are combinational pass-through of rd_data0/rd_data1, valid only while mul_valid=1.
  - mul_valid is 0 in every cycle not preceded by a grant, so back-to-back grants give back-to-back issues.
- Result tracking:
  - mul_out_valid decrements outstanding.
  - An issue and a return in the same cycle leave outstanding unchanged.
  - outstanding never underflows: a stray mul_out_valid at outstanding==0 is ignored.
- State DRAIN:
  - rd_req=0, cmd_ready=0.
  - When outstanding reaches 0 with no issue pending (the final mul_valid already sent), pulse cmd_done for one cycle and go to IDLE.
  - busy drops in the same cycle cmd_done is asserted.
- Latency: the multiplier returns 6 cycles after mul_valid. cmd_done comes 1 cycle after the last mul_out_valid, i.e. cycle t_lastgnt+8.
- Reset mid-operation: abort to IDLE with no cmd_done. Late mul_out_valid strobes from the aborted command are ignored because outstanding is held at 0.
- Address arithmetic wraps modulo 2^REQ_ADDR_WIDTH.

Test Plan:
1. Reset, then cmd len=1, vs1=0x10, vs2=0x20, vd=0x30, sew=2, rd_gnt tied 1 -> one rd_req with rd_addr0=0x10 and rd_addr1=0x20; mul_valid 1 cycle later with mul_addr=0x30, sew=2; returning mul_out_valid 6 cycles after that -> cmd_done 1 cycle later; cmd_ready=0 throughout.
2. len=4, widen=1, vd=0x40, rd_gnt always 1 -> four consecutive mul_valid with mul_addr 0x40, 0x42, 0x44, 0x46; mul_vec0 equals rd_data0 in each; exactly one cmd_done.
3. len=3, rd_gnt pattern 1,0,0,1,1 -> rd_addr0 holds vs1+1 through both deny cycles; mul_valid pattern 1,0,0,1,1 delayed one cycle; cmd_done only after the third result returns.
4. len=0 -> no rd_req and no mul_valid; cmd_done pulses the cycle after accept; cmd_ready stays 1.
5. Assert rst after 2 of 5 chunks are granted -> next cycle all outputs are 0 and cmd_ready=1; two late mul_out_valid strobes are ignored; a new len=1 command then completes normally with a single cmd_done.
6. Back-to-back commands: cmd_valid held high -> second command accepted only in the cycle after the first command's cmd_done; cmd_ready is 0 during ISSUE and DRAIN.

Source files
------------

// File: rtl/vmul_seq.sv
// vmul_seq: issue sequencer for the vector multiplier.
// Accepts one command at a time, reads both operands one chunk per granted
// cycle from a shared register-file port, and forwards each chunk to the
// multiplier. Results are counted back in, and cmd_done pulses after the last one.
module vmul_seq #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int SEW_WIDTH      = 2,
  parameter int OPSEL_WIDTH    = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vs1,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vs2,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vd,
  input  logic [CNT_WIDTH-1:0]      cmd_len,
  input  logic [SEW_WIDTH-1:0]      cmd_sew,
  input  logic [OPSEL_WIDTH-1:0]    cmd_opsel,
  input  logic                      cmd_widen,
  output logic                      rd_req,
  input  logic                      rd_gnt,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr0,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr1,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data1,
  output logic [REQ_DATA_WIDTH-1:0] mul_vec0,
  output logic [REQ_DATA_WIDTH-1:0] mul_vec1,
  output logic                      mul_valid,
  output logic [SEW_WIDTH-1:0]      mul_sew,
  output logic [OPSEL_WIDTH-1:0]    mul_opsel,
  output logic                      mul_widen,
  output logic [REQ_ADDR_WIDTH-1:0] mul_addr,
  input  logic                      mul_out_valid,
  output logic                      busy,
  output logic                      cmd_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;

  // Latched command and running chunk pointers
  logic [REQ_ADDR_WIDTH-1:0] r_addr0;
  logic [REQ_ADDR_WIDTH-1:0] r_addr1;
  logic [REQ_ADDR_WIDTH-1:0] r_dst;
  logic [CNT_WIDTH-1:0]      r_len;
  logic [CNT_WIDTH-1:0]      r_idx;
  logic [SEW_WIDTH-1:0]      r_sew;
  logic [OPSEL_WIDTH-1:0]    r_opsel;
  logic                      r_widen;

  // Issue stage and completion tracking
  logic                      r_mul_valid;
  logic [REQ_ADDR_WIDTH-1:0] r_mul_addr;
  logic [CNT_WIDTH-1:0]      r_outstanding;
  logic                      r_zero_done;

  logic                      w_accept;
  logic                      w_grant;
  logic                      w_last;
  logic                      w_ret;
  logic                      w_drain_done;
  logic [REQ_ADDR_WIDTH-1:0] w_stride;

  assign w_accept     = cmd_valid & cmd_ready;
  assign w_grant      = rd_req & rd_gnt;
  assign w_last       = (r_idx == (r_len - CNT_WIDTH'(1)));
  // A return with nothing outstanding is a leftover from an aborted command.
  assign w_ret        = mul_out_valid & (r_outstanding != '0);
  // Finished once every issued chunk has come back and no issue is in flight.
  assign w_drain_done = (r_state == S_DRAIN) & (r_outstanding == '0) & ~r_mul_valid;
  // Widening results occupy two destination chunks per source chunk.
  assign w_stride     = r_widen ? REQ_ADDR_WIDTH'(2) : REQ_ADDR_WIDTH'(1);

  assign rd_addr0  = r_addr0;
  assign rd_addr1  = r_addr1;
  assign mul_valid = r_mul_valid;
  assign mul_addr  = r_mul_addr;
  assign mul_sew   = r_sew;
  assign mul_opsel = r_opsel;
  assign mul_widen = r_widen;
  // Read data arrives the cycle after the grant, i.e. exactly when mul_valid is high.
  assign mul_vec0  = r_mul_valid ? rd_data0 : '0;
  assign mul_vec1  = r_mul_valid ? rd_data1 : '0;
  assign cmd_done  = w_drain_done | r_zero_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rd_req       = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_len != '0)) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_req = 1'b1;
        busy   = 1'b1;
        if (rd_gnt && w_last) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = ~w_drain_done;
        if (w_drain_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Command latch, address walk and registered issue to the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr0     <= '0;
      r_addr1     <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_sew       <= '0;
      r_opsel     <= '0;
      r_widen     <= 1'b0;
      r_mul_valid <= 1'b0;
      r_mul_addr  <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_mul_valid <= w_grant;
      r_zero_done <= w_accept & (cmd_len == '0);
      if (w_accept) begin
        r_addr0 <= cmd_vs1;
        r_addr1 <= cmd_vs2;
        r_dst   <= cmd_vd;
        r_len   <= cmd_len;
        r_idx   <= '0;
        r_sew   <= cmd_sew;
        r_opsel <= cmd_opsel;
        r_widen <= cmd_widen;
      end else if (w_grant) begin
        r_addr0    <= r_addr0 + REQ_ADDR_WIDTH'(1);
        r_addr1    <= r_addr1 + REQ_ADDR_WIDTH'(1);
        r_dst      <= r_dst + w_stride;
        r_idx      <= r_idx + CNT_WIDTH'(1);
        r_mul_addr <= r_dst;
      end
    end
  end

  // Outstanding-result counter; a simultaneous issue and return cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_grant, w_ret})
        2'b10:   r_outstanding <= r_outstanding + CNT_WIDTH'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_WIDTH'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_vmul_seq.sv
// tb_vmul_seq: directed, table-driven bench for the vector-multiply issue sequencer.
module tb_vmul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_vs1, cmd_vs2, cmd_vd;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_sew, cmd_opsel;
  logic        cmd_widen;
  logic        rd_req, rd_gnt;
  logic [31:0] rd_addr0, rd_addr1;
  logic [63:0] rd_data0, rd_data1;
  logic [63:0] mul_vec0, mul_vec1;
  logic        mul_valid;
  logic [1:0]  mul_sew, mul_opsel;
  logic        mul_widen;
  logic [31:0] mul_addr;
  logic        mul_out_valid;
  logic        busy, cmd_done;

  always #5 clk = ~clk;

  vmul_seq #(
    .REQ_DATA_WIDTH(64), .REQ_ADDR_WIDTH(32), .SEW_WIDTH(2),
    .OPSEL_WIDTH(2), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
    .cmd_len(cmd_len), .cmd_sew(cmd_sew), .cmd_opsel(cmd_opsel), .cmd_widen(cmd_widen),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .mul_vec0(mul_vec0), .mul_vec1(mul_vec1), .mul_valid(mul_valid),
    .mul_sew(mul_sew), .mul_opsel(mul_opsel), .mul_widen(mul_widen), .mul_addr(mul_addr),
    .mul_out_valid(mul_out_valid), .busy(busy), .cmd_done(cmd_done)
  );

  typedef struct {
    logic [31:0] vs1;
    logic [31:0] vs2;
    logic [31:0] vd;
    logic [7:0]  len;
    logic [1:0]  sew;
    logic [1:0]  opsel;
    logic        widen;
    logic [15:0] gpat;        // grant per ISSUE cycle, bit 0 first; all 1 beyond
    int          exp_lat;     // accept cycle to cmd_done cycle
    int          exp_issues;
    int          exp_req;     // cycles with rd_req high
    int          exp_rlow;    // cycles with cmd_ready low
    logic [31:0] exp_last_mul;
    logic [31:0] exp_last_rd0;
  } vec_t;

  vec_t vecs[5];

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;
  bit live_en = 1'b0;
  bit chk_zero = 1'b0;
  logic [15:0] gpat = 16'hFFFF;
  int gidx = 0;
  bit prev_gnt = 1'b0;
  logic [31:0] cur_vs1, cur_vs2, cur_vd;
  logic [1:0]  cur_sew, cur_opsel;
  logic        cur_widen;
  int gcount = 0, mcount = 0, req_cycles = 0, rlow_cnt = 0;
  int done_count = 0, acc_count = 0, acc_cyc = 0, done_cyc = 0;
  bit ready_at_done = 1'b0;
  logic [31:0] last_mul_addr = '0, last_rd0 = '0;
  bit retq[256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, settle, observe/check, advance.
  task automatic run_cycle();
    logic [31:0] ea;
    if (rd_req === 1'b1) begin
      rd_gnt = (gidx < 16) ? gpat[gidx] : 1'b1;
      gidx++;
    end else begin
      rd_gnt = 1'b0;
    end
    mul_out_valid = retq[cyc % 256];
    retq[cyc % 256] = 1'b0;
    rd_data0 = {$urandom, $urandom};
    rd_data1 = {$urandom, $urandom};
    #4;
    if (mul_valid === 1'b1) retq[(cyc + 6) % 256] = 1'b1;
    if (live_en) begin
      if (cmd_valid && cmd_ready) begin
        acc_count++; acc_cyc = cyc;
        cur_vs1 = cmd_vs1; cur_vs2 = cmd_vs2; cur_vd = cmd_vd;
        cur_sew = cmd_sew; cur_opsel = cmd_opsel; cur_widen = cmd_widen;
        gcount = 0; mcount = 0; req_cycles = 0; rlow_cnt = 0; done_count = 0; gidx = 0;
      end
      if (!cmd_ready) rlow_cnt++;
      if (rd_req) begin
        req_cycles++;
        ea = cur_vs1 + gcount;
        chk("rd_addr0", rd_addr0, ea);
        ea = cur_vs2 + gcount;
        chk("rd_addr1", rd_addr1, ea);
        if (rd_gnt) begin
          last_rd0 = rd_addr0;
          gcount++;
        end
      end
      chk("mul_valid", mul_valid, prev_gnt);
      prev_gnt = rd_req && rd_gnt;
      if (mul_valid) begin
        ea = cur_vd + mcount * (cur_widen ? 2 : 1);
        chk("mul_addr", mul_addr, ea);
        chk("mul_sew", mul_sew, cur_sew);
        chk("mul_opsel", mul_opsel, cur_opsel);
        chk("mul_widen", mul_widen, cur_widen);
        chk("mul_vec0", mul_vec0, rd_data0);
        chk("mul_vec1", mul_vec1, rd_data1);
        last_mul_addr = mul_addr;
        mcount++;
      end
      if (busy) chk("ready_while_busy", cmd_ready, 0);
      if (cmd_done) begin
        done_count++;
        done_cyc = cyc;
        ready_at_done = cmd_ready;
        chk("busy_at_done", busy, 0);
      end
      if (chk_zero) begin
        chk("z_rd_req", rd_req, 0);
        chk("z_rd_addr0", rd_addr0, 0);
        chk("z_rd_addr1", rd_addr1, 0);
        chk("z_mul_valid", mul_valid, 0);
        chk("z_mul_addr", mul_addr, 0);
        chk("z_mul_sew", mul_sew, 0);
        chk("z_mul_opsel", mul_opsel, 0);
        chk("z_mul_widen", mul_widen, 0);
        chk("z_mul_vec0", mul_vec0, 0);
        chk("z_busy", busy, 0);
        chk("z_cmd_done", cmd_done, 0);
        chk("z_cmd_ready", cmd_ready, 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_cmd(input vec_t v, input int id);
    cmd_vs1 = v.vs1; cmd_vs2 = v.vs2; cmd_vd = v.vd; cmd_len = v.len;
    cmd_sew = v.sew; cmd_opsel = v.opsel; cmd_widen = v.widen;
    gpat = v.gpat;
    cmd_valid = 1'b1;
    run_cycle();
    cmd_valid = 1'b0;
    for (int n = 0; n < 60 && done_count == 0; n++) run_cycle();
    repeat (8) run_cycle();
    chk("done_count", done_count, 1);
    chk("done_latency", done_cyc - acc_cyc, v.exp_lat);
    chk("grant_count", gcount, v.exp_issues);
    chk("issue_count", mcount, v.exp_issues);
    chk("rd_req_cycles", req_cycles, v.exp_req);
    chk("ready_low_cycles", rlow_cnt, v.exp_rlow);
    if (v.exp_issues > 0) begin
      chk("last_mul_addr", last_mul_addr, v.exp_last_mul);
      chk("last_rd_addr0", last_rd0, v.exp_last_rd0);
    end
    $display("cmd %0d: len=%0d widen=%0d issues=%0d done_lat=%0d dones=%0d",
             id, v.len, v.widen, mcount, done_cyc - acc_cyc, done_count);
  endtask

  initial begin
    int a1, a2, da;
    vec_t post;

    vecs[0] = '{vs1:32'h10, vs2:32'h20, vd:32'h30, len:8'd1, sew:2'd2, opsel:2'd1, widen:1'b0,
                gpat:16'hFFFF, exp_lat:9, exp_issues:1, exp_req:1, exp_rlow:9,
                exp_last_mul:32'h30, exp_last_rd0:32'h10};
    vecs[1] = '{vs1:32'h100, vs2:32'h200, vd:32'h40, len:8'd4, sew:2'd1, opsel:2'd2, widen:1'b1,
                gpat:16'hFFFF, exp_lat:12, exp_issues:4, exp_req:4, exp_rlow:12,
                exp_last_mul:32'h46, exp_last_rd0:32'h103};
    vecs[2] = '{vs1:32'h50, vs2:32'h60, vd:32'h70, len:8'd3, sew:2'd0, opsel:2'd3, widen:1'b0,
                gpat:16'hFFF9, exp_lat:13, exp_issues:3, exp_req:5, exp_rlow:13,
                exp_last_mul:32'h72, exp_last_rd0:32'h52};
    vecs[3] = '{vs1:32'h1, vs2:32'h2, vd:32'h3, len:8'd0, sew:2'd1, opsel:2'd1, widen:1'b0,
                gpat:16'hFFFF, exp_lat:1, exp_issues:0, exp_req:0, exp_rlow:0,
                exp_last_mul:32'h0, exp_last_rd0:32'h0};
    vecs[4] = '{vs1:32'hFFFF_FFFF, vs2:32'hFFFF_FFFE, vd:32'hFFFF_FFFF, len:8'd2, sew:2'd3,
                opsel:2'd0, widen:1'b1, gpat:16'hFFFF, exp_lat:10, exp_issues:2, exp_req:2,
                exp_rlow:10, exp_last_mul:32'h0000_0001, exp_last_rd0:32'h0000_0000};
    post = '{vs1:32'hC0, vs2:32'hD0, vd:32'hE0, len:8'd1, sew:2'd1, opsel:2'd1, widen:1'b0,
             gpat:16'hFFFF, exp_lat:9, exp_issues:1, exp_req:1, exp_rlow:9,
             exp_last_mul:32'hE0, exp_last_rd0:32'hC0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vd = '0; cmd_len = '0;
    cmd_sew = '0; cmd_opsel = '0; cmd_widen = 1'b0; rd_gnt = 1'b0;
    rd_data0 = '0; rd_data1 = '0; mul_out_valid = 1'b0;
    cur_vs1 = '0; cur_vs2 = '0; cur_vd = '0; cur_sew = '0; cur_opsel = '0; cur_widen = 1'b0;
    foreach (retq[i]) retq[i] = 1'b0;
    @(posedge clk); #1;

    // Reset state
    repeat (3) run_cycle();
    rst = 1'b0;
    live_en = 1'b1;
    chk_zero = 1'b1;
    run_cycle();
    chk_zero = 1'b0;

    // Table-driven commands
    for (int i = 0; i < 5; i++) do_cmd(vecs[i], i);

    // Reset after two of five chunks granted
    cmd_vs1 = 32'h80; cmd_vs2 = 32'h90; cmd_vd = 32'hA0; cmd_len = 8'd5;
    cmd_sew = 2'd2; cmd_opsel = 2'd2; cmd_widen = 1'b0;
    gpat = 16'hFFFB;
    cmd_valid = 1'b1;
    run_cycle();
    cmd_valid = 1'b0;
    run_cycle();
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    chk("abort_grants", gcount, 2);
    chk_zero = 1'b1;
    run_cycle();
    chk_zero = 1'b0;
    done_count = 0;
    repeat (10) run_cycle();
    chk("abort_no_done", done_count, 0);
    $display("abort: grants=%0d dones_after_reset=%0d", gcount, done_count);
    do_cmd(post, 5);

    // Back-to-back commands with cmd_valid held high
    cmd_vs1 = 32'h200; cmd_vs2 = 32'h300; cmd_vd = 32'h400; cmd_len = 8'd2;
    cmd_sew = 2'd1; cmd_opsel = 2'd2; cmd_widen = 1'b0;
    gpat = 16'hFFFF;
    a1 = acc_count;
    cmd_valid = 1'b1;
    run_cycle();
    chk("b2b_first_accept", acc_count, a1 + 1);
    a1 = acc_cyc;
    cmd_vs1 = 32'h500; cmd_vs2 = 32'h510; cmd_vd = 32'h600; cmd_len = 8'd1;
    for (int n = 0; n < 60 && acc_cyc == a1; n++) run_cycle();
    cmd_valid = 1'b0;
    a2 = acc_cyc;
    da = done_cyc;
    chk("b2b_accept_gap", a2 - a1, 11);
    chk("b2b_accept_after_done", a2 - da, 1);
    chk("b2b_ready_at_done", ready_at_done, 0);
    for (int n = 0; n < 60 && done_count == 0; n++) run_cycle();
    repeat (8) run_cycle();
    chk("b2b_done_count", done_count, 1);
    chk("b2b_done_latency", done_cyc - a2, 9);
    chk("b2b_mul_addr", last_mul_addr, 32'h600);
    $display("b2b: first_accept=%0d second_accept=%0d first_done=%0d", a1, a2, da);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
